// File: rtl/pgs_pciex4_fifo_rd_fwft.sv
// -----------------------------------------------------------------------------
// pgs_pciex4_fifo_rd_fwft
//
// First-word-fall-through read adapter between a single-clock FIFO (pointer
// controller + RAM with RAM_RD_LAT read latency) and a valid/ready stream.
// Reads are issued into a 4-entry output buffer. A read is only issued when a
// buffer slot is guaranteed for it, counting both buffered and in-flight words.
//
// Parameters
//   DATA_WIDTH   width of RAM read data and m_data
//   RAM_RD_LAT   cycles from fifo_r_en to valid ram_rd_data (1 or 2)
//
// Ports
//   clk          single clock
//   rst          asynchronous, active-high reset
//   fifo_rempty  registered empty flag from the FIFO pointer controller
//   fifo_r_en    read strobe to the FIFO (combinational)
//   ram_rd_data  RAM read data, valid RAM_RD_LAT cycles after fifo_r_en
//   m_valid      output word available
//   m_ready      downstream accepts the word
//   m_data       output word (driven from buffer registers only)
//   buf_cnt      words held in the output buffer, 0..4
//   rd_busy      reads in flight or buffer not empty
// -----------------------------------------------------------------------------
module pgs_pciex4_fifo_rd_fwft #(
    parameter int DATA_WIDTH = 64,
    parameter int RAM_RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_rempty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [2:0]            buf_cnt,
    output logic                  rd_busy
);

    logic [DATA_WIDTH-1:0] buf_mem_q [4];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [RAM_RD_LAT-1:0] tag_q, tag_d;
    logic                  first_q;
    logic [1:0]            inflight_cnt;
    logic [3:0]            occupancy;
    logic                  push;
    logic                  pop;

    // A tag leaving the end of the shift register marks the cycle in which
    // ram_rd_data carries the word for that read.
    assign push = tag_q[RAM_RD_LAT-1];
    assign pop  = m_valid & m_ready;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RAM_RD_LAT; i++) begin
            inflight_cnt = inflight_cnt + {1'b0, tag_q[i]};
        end
    end

    assign occupancy = {1'b0, cnt_q} + {2'b00, inflight_cnt};

    // A pop this cycle frees a slot, so the read may be issued in the same
    // cycle. first_q holds reads off during reset and the first cycle after.
    assign fifo_r_en = ~first_q & ~fifo_rempty & (occupancy < (4'd4 + {3'b000, pop}));

    generate
        if (RAM_RD_LAT == 1) begin : g_lat1
            assign tag_d = fifo_r_en;
        end else begin : g_latn
            assign tag_d = {tag_q[RAM_RD_LAT-2:0], fifo_r_en};
        end
    endgenerate

    assign wr_ptr_d = wr_ptr_q + {1'b0, push};
    assign rd_ptr_d = rd_ptr_q + {1'b0, pop};
    assign cnt_d    = cnt_q + {2'b00, push} - {2'b00, pop};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            tag_q    <= '0;
            first_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            tag_q    <= tag_d;
            first_q  <= 1'b0;
        end
    end

    // NOTE: the buffer storage has no reset; stale entries are unreachable
    // because m_data is forced to zero whenever the buffer count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem_q[wr_ptr_q] <= ram_rd_data;
        end
    end

    assign m_valid = (cnt_q != 3'd0);
    assign m_data  = m_valid ? buf_mem_q[rd_ptr_q] : '0;
    assign buf_cnt = cnt_q;
    assign rd_busy = (inflight_cnt != 2'd0) | m_valid;

endmodule
